// File: rtl/shift_pkg.sv
// ============================================================================
// Module : shift_pkg
// Brief  : Shared types and sizing helpers for the serial shift-in receiver.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package shift_pkg;

    localparam int DEFAULT_N = 14;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_e;

    // Counter must be able to hold the value N itself, not just N-1.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/shift_in_deserializer_if.sv
// ============================================================================
// Module : shift_in_deserializer_if
// Brief  : Serial input, parallel valid/ready output and status bundle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface shift_in_deserializer_if
    import shift_pkg::*;
#(
    parameter int N = DEFAULT_N
);
    localparam int CW = cnt_w(N);

    logic          start;
    logic          bit_valid;
    logic          bit_in;
    logic          data_ready;
    logic [N-1:0]  data_out;
    logic          data_valid;
    logic          busy;
    logic [CW-1:0] bit_count;
    logic          overrun;

    modport master (
        output start, bit_valid, bit_in, data_ready,
        input  data_out, data_valid, busy, bit_count, overrun
    );

    modport slave (
        input  start, bit_valid, bit_in, data_ready,
        output data_out, data_valid, busy, bit_count, overrun
    );

endinterface

`default_nettype wire

// File: rtl/shift_in_bit_counter.sv
// ============================================================================
// Module : shift_in_bit_counter
// Brief  : Received-bit counter with a flag on the bit that completes a word.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module shift_in_bit_counter
    import shift_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    input  wire logic                  clear,
    input  wire logic                  increment,
    output logic [cnt_w(N)-1:0]        count,
    output logic                       last_bit
);
    localparam int            CW   = cnt_w(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (increment) begin
            count <= count + 1'b1;
        end
    end

    assign last_bit = (count == LAST);

endmodule

`default_nettype wire

// File: rtl/shift_in_deserializer.sv
// ============================================================================
// Module : shift_in_deserializer
// Brief  : LSB-first serial-to-parallel receiver with valid/ready output.
//          Define SHIFT_IN_MSB_FIRST_EN to receive MSB first instead.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module shift_in_deserializer
    import shift_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  wire logic                clk,
    input  wire logic                reset,
    shift_in_deserializer_if.slave   bus
);
    localparam int         CW         = cnt_w(N);
    localparam logic [1:0] ST_IDLE    = IDLE;
    localparam logic [1:0] ST_COLLECT = COLLECT;
    localparam logic [1:0] ST_HOLD    = HOLD;

    logic [1:0]    state;
    logic [N-1:0]  sreg;
    logic [N-1:0]  shifted;
    logic          ovr;
    logic          start_ok;
    logic          cnt_clear;
    logic          cnt_inc;
    logic          last_bit;
    logic [CW-1:0] count;

`ifdef SHIFT_IN_MSB_FIRST_EN
    assign shifted = {sreg[N-2:0], bus.bit_in};
`else
    assign shifted = {bus.bit_in, sreg[N-1:1]};
`endif

    // A start in HOLD only counts when the current word is handed off with it.
    always_comb begin
        start_ok  = bus.start && ((state == ST_IDLE) || (state == ST_COLLECT) ||
                                  ((state == ST_HOLD) && bus.data_ready));
        cnt_clear = start_ok || ((state == ST_HOLD) && bus.data_ready);
        cnt_inc   = (state == ST_COLLECT) && bus.bit_valid && !bus.start;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            sreg  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        state <= ST_COLLECT;
                        sreg  <= '0;
                    end
                end
                ST_COLLECT: begin
                    if (bus.start) begin
                        sreg <= '0;
                    end else if (bus.bit_valid) begin
                        sreg <= shifted;
                        if (last_bit) begin
                            state <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (bus.data_ready) begin
                        if (bus.start) begin
                            state <= ST_COLLECT;
                            sreg  <= '0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovr <= 1'b0;
        end else if (start_ok) begin
            ovr <= 1'b0;
        end else if ((state == ST_HOLD) && bus.bit_valid) begin
            ovr <= 1'b1;
        end
    end

    shift_in_bit_counter #(.N(N)) u_counter (
        .clk       (clk),
        .reset     (reset),
        .clear     (cnt_clear),
        .increment (cnt_inc),
        .count     (count),
        .last_bit  (last_bit)
    );

    assign bus.data_out   = sreg;
    assign bus.data_valid = (state == ST_HOLD);
    assign bus.busy       = (state == ST_COLLECT);
    assign bus.bit_count  = count;
    assign bus.overrun    = ovr;

endmodule

`default_nettype wire
